// File: rtl/udp_rx_cmd_pkg.sv
// rtl/udp_rx_cmd_pkg.sv - shared types and constants for the UDP receive command controller
package udp_rx_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam logic [7:0] MAGIC_DEF     = 8'hA5;
  localparam int         FRAME_LEN_DEF = 8;

  localparam int IDX_MAGIC = 0;
  localparam int IDX_OP    = 1;
  localparam int IDX_ADDR  = 2;
  localparam int IDX_DATA0 = 3;
  localparam int IDX_CSUM  = 7;

endpackage

// File: rtl/udp_sat_cnt.sv
// rtl/udp_sat_cnt.sv - saturating event counter
module udp_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/udp_rx_cmd_ctrl.sv
// rtl/udp_rx_cmd_ctrl.sv - frames UDP payloads, parses the 8-byte command header, holds one command
module udp_rx_cmd_ctrl
  import udp_rx_cmd_pkg::*;
#(
  parameter logic [7:0] MAGIC     = MAGIC_DEF,
  parameter int         FRAME_LEN = FRAME_LEN_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             udp_rx_clk,
  input  logic             reset,
  input  logic             app_rx_data_valid,
  input  logic [7:0]       app_rx_data,
  input  logic [15:0]      app_rx_data_length,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_opcode,
  output logic [7:0]       cmd_addr,
  output logic [31:0]      cmd_data,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [15:0]      len_q, cur_len;
  logic [7:0]       hdr_q [0:IDX_CSUM-1];
  logic [7:0]       csum_q;
  logic             hdr_ok_q;
  logic             first_byte, last_byte, at_csum, hdr_chk, frame_good;
  logic             load, accept, drop, err_inc;
  logic             cmd_valid_q;
  logic [7:0]       cmd_opcode_q, cmd_addr_q;
  logic [31:0]      cmd_data_q;

  assign first_byte = (idx_q == '0);
  assign cur_len    = first_byte ? ((app_rx_data_length == 16'd0) ? 16'd1 : app_rx_data_length)
                                 : len_q;
  assign last_byte  = app_rx_data_valid && (32'(idx_q) == (32'(cur_len) - 32'd1));
  assign at_csum    = (32'(idx_q) == 32'(FRAME_LEN - 1));
  assign hdr_chk    = (hdr_q[IDX_MAGIC] == MAGIC) && (app_rx_data == csum_q);
  // Long frames decided the header at the checksum byte; the verdict is carried through DRAIN.
  assign frame_good = last_byte && ((state_q == ST_COLLECT && at_csum) ? hdr_chk
                                   : ((state_q == ST_DRAIN) && hdr_ok_q));

  assign accept  = cmd_valid_q && cmd_ready;
  assign load    = frame_good && (!cmd_valid_q || cmd_ready);
  assign drop    = frame_good && cmd_valid_q && !cmd_ready;
  assign err_inc = last_byte && !frame_good;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (app_rx_data_valid) begin
      idx_d = last_byte ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (app_rx_data_valid && !last_byte) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (app_rx_data_valid) begin
          if (last_byte)    state_d = ST_IDLE;
          else if (at_csum) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (app_rx_data_valid && last_byte) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= 16'd0;
      csum_q   <= 8'd0;
      hdr_ok_q <= 1'b0;
      for (int i = 0; i < IDX_CSUM; i++) hdr_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (app_rx_data_valid) begin
        if (first_byte) len_q <= cur_len;
        if ((state_q != ST_DRAIN) && (32'(idx_q) < 32'(IDX_CSUM))) begin
          hdr_q[idx_q[2:0]] <= app_rx_data;
          csum_q            <= first_byte ? app_rx_data : (csum_q ^ app_rx_data);
        end
        if ((state_q == ST_COLLECT) && at_csum) hdr_ok_q <= hdr_chk;
      end
    end
  end

  // A pending command is only replaced when it is being accepted in the same cycle.
  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= 8'd0;
      cmd_addr_q   <= 8'd0;
      cmd_data_q   <= 32'd0;
    end else if (load) begin
      cmd_valid_q  <= 1'b1;
      cmd_opcode_q <= hdr_q[IDX_OP];
      cmd_addr_q   <= hdr_q[IDX_ADDR];
      cmd_data_q   <= {hdr_q[IDX_DATA0], hdr_q[IDX_DATA0+1], hdr_q[IDX_DATA0+2], hdr_q[IDX_DATA0+3]};
    end else if (accept) begin
      cmd_valid_q  <= 1'b0;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;

  udp_sat_cnt #(.W(CNT_W)) u_ok_cnt (
    .clk_i(udp_rx_clk), .reset_i(reset), .inc_i(load), .cnt_o(frame_ok_cnt)
  );

  udp_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk_i(udp_rx_clk), .reset_i(reset), .inc_i(err_inc), .cnt_o(err_cnt)
  );

  udp_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk_i(udp_rx_clk), .reset_i(reset), .inc_i(drop), .cnt_o(drop_cnt)
  );

endmodule

// File: tb/tb_udp_rx_cmd_ctrl.sv
// tb/tb_udp_rx_cmd_ctrl.sv - scoreboard bench for udp_rx_cmd_ctrl
module tb_udp_rx_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [15:0] rx_len = 16'd0;
  logic        cmd_ready = 1'b0;

  logic        cmd_valid, cmd_valid_s;
  logic [7:0]  cmd_opcode, cmd_addr, cmd_opcode_s, cmd_addr_s;
  logic [31:0] cmd_data, cmd_data_s;
  logic [15:0] ok_cnt, err_cnt, drop_cnt;
  logic [3:0]  ok_cnt_s, err_cnt_s, drop_cnt_s;

  always #5 clk = ~clk;

  udp_rx_cmd_ctrl dut (
    .udp_rx_clk(clk), .reset(reset),
    .app_rx_data_valid(rx_valid), .app_rx_data(rx_data), .app_rx_data_length(rx_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  // Narrow-counter copy sharing the same stimulus so saturation is reachable quickly.
  udp_rx_cmd_ctrl #(.CNT_W(4)) dut_s (
    .udp_rx_clk(clk), .reset(reset),
    .app_rx_data_valid(rx_valid), .app_rx_data(rx_data), .app_rx_data_length(rx_len),
    .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode_s), .cmd_addr(cmd_addr_s), .cmd_data(cmd_data_s),
    .frame_ok_cnt(ok_cnt_s), .err_cnt(err_cnt_s), .drop_cnt(drop_cnt_s)
  );

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  int         checks = 0;
  int         failures = 0;
  cmd_t       exp_q[$];
  logic [7:0] fb[$];
  logic [7:0] mb[$];
  int         m_len, m_ok, m_err, m_drop;
  bit         m_pend;
  bit         m_fend, m_good;
  logic [7:0] m_x;
  cmd_t       m_nc, m_got;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects each frame's bytes and decides its fate from the frame rules.
  always @(posedge clk) begin
    if (reset) begin
      mb.delete();
      exp_q.delete();
      m_ok = 0; m_err = 0; m_drop = 0; m_pend = 0;
    end else begin
      m_fend = 0;
      m_good = 0;
      if (rx_valid) begin
        if (mb.size() == 0) m_len = (rx_len == 16'd0) ? 1 : int'(rx_len);
        mb.push_back(rx_data);
        if (mb.size() == m_len) begin
          m_fend = 1;
          if (m_len >= 8) begin
            m_x = 8'd0;
            for (int i = 0; i < 7; i++) m_x = m_x ^ mb[i];
            m_good = (mb[0] == 8'hA5) && (mb[7] == m_x);
            m_nc.op   = mb[1];
            m_nc.addr = mb[2];
            m_nc.data = {mb[3], mb[4], mb[5], mb[6]};
          end
          mb.delete();
        end
      end
      if (m_fend && !m_good) m_err++;
      if (m_good) begin
        if (!m_pend || cmd_ready) begin
          exp_q.push_back(m_nc);
          m_ok++;
          m_pend = 1;
        end else begin
          m_drop++;
        end
      end else if (m_pend && cmd_ready) begin
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_valid", 64'(cmd_valid), 64'(m_pend));
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_unexpected: got command %0h expected none at %0t", cmd_data, $time);
        end else begin
          m_got = exp_q.pop_front();
          chk("cmd_opcode", 64'(cmd_opcode), 64'(m_got.op));
          chk("cmd_addr", 64'(cmd_addr), 64'(m_got.addr));
          chk("cmd_data", 64'(cmd_data), 64'(m_got.data));
        end
      end
      chk("frame_ok_cnt", 64'(ok_cnt), 64'(sat(m_ok, 16)));
      chk("err_cnt", 64'(err_cnt), 64'(sat(m_err, 16)));
      chk("drop_cnt", 64'(drop_cnt), 64'(sat(m_drop, 16)));
      chk("err_cnt_sat4", 64'(err_cnt_s), 64'(sat(m_err, 4)));
      chk("ok_cnt_sat4", 64'(ok_cnt_s), 64'(sat(m_ok, 4)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 good, 1 bad magic, 2 bad checksum, 3 short
  task automatic build(input int kind, input int len, input logic [7:0] op,
                       input logic [7:0] addr, input logic [31:0] d);
    logic [7:0] x;
    int n;
    n = (len < 1) ? 1 : len;
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    fb[0] = 8'hA5;
    if (kind != 3) begin
      if (kind == 1) fb[0] = 8'h5A;
      fb[1] = op; fb[2] = addr;
      fb[3] = d[31:24]; fb[4] = d[23:16]; fb[5] = d[15:8]; fb[6] = d[7:0];
      x = 8'd0;
      for (int i = 0; i < 7; i++) x = x ^ fb[i];
      fb[7] = (kind == 2) ? (x ^ 8'($urandom_range(1, 255))) : x;
    end
  endtask

  // mode: 0 ready low, 1 ready high, 2 random, 3 high only on the last byte
  task automatic send(input int len_field, input int count, input int gaps, input int mode);
    for (int i = 0; i < count; i++) begin
      if (gaps > 0) begin
        repeat ($urandom_range(0, gaps)) begin
          rx_valid  = 1'b0;
          cmd_ready = (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1));
          tick();
        end
      end
      rx_valid  = 1'b1;
      rx_data   = fb[i];
      rx_len    = (i == 0) ? 16'(len_field) : 16'($urandom);
      cmd_ready = (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1))
                  || ((mode == 3) && (i == count - 1));
      tick();
    end
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic accept_one();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
  endtask

  initial begin
    int kind, len;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    build(0, 8, 8'h01, 8'h10, 32'hDEADBEEF);
    send(8, 8, 0, 0);
    tick();
    accept_one();

    build(0, 12, 8'h02, 8'h20, 32'h12345678);
    send(12, 12, 3, 0);
    build(0, 8, 8'h03, 8'h30, 32'hCAFEF00D);
    send(8, 8, 0, 1);
    accept_one();

    build(1, 8, 8'h04, 8'h40, 32'h1);
    send(8, 8, 0, 0);
    build(2, 8, 8'h05, 8'h50, 32'h2);
    send(8, 8, 0, 0);
    build(3, 5, 8'h00, 8'h00, 32'h0);
    send(5, 5, 0, 0);
    build(3, 0, 8'h00, 8'h00, 32'h0);
    send(0, 1, 0, 0);
    repeat (2) tick();

    build(0, 8, 8'h11, 8'h01, 32'hAAAA0001);
    send(8, 8, 0, 0);
    build(0, 9, 8'h22, 8'h02, 32'hBBBB0002);
    send(9, 9, 0, 0);
    tick();
    accept_one();

    build(0, 8, 8'h33, 8'h03, 32'hCCCC0003);
    send(8, 8, 0, 0);
    build(0, 8, 8'h44, 8'h04, 32'hDDDD0004);
    send(8, 8, 0, 3);
    accept_one();

    build(0, 10, 8'h55, 8'h05, 32'hEEEE0005);
    send(10, 4, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    build(0, 8, 8'h66, 8'h06, 32'hFFFF0006);
    send(8, 8, 1, 0);
    accept_one();

    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 3);
      len  = (kind == 3) ? $urandom_range(0, 7) : $urandom_range(8, 15);
      build(kind, len, 8'($urandom), 8'($urandom), 32'($urandom));
      send(len, (len < 1) ? 1 : len, 2, 2);
      repeat ($urandom_range(0, 2)) begin
        cmd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      cmd_ready = 1'b0;
    end

    for (int f = 0; f < 18; f++) begin
      build(2, 8, 8'h77, 8'h07, 32'($urandom));
      send(8, 8, 0, 1);
    end

    cmd_ready = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b0;
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
